// File: rtl/keypad_scan.sv
// keypad_scan: 3x3 keypad row scanner with per-frame key resolution and frame-count debounce.
// Optional auto-repeat of key_valid while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan #(
  parameter int SCAN_DIV = 12000,
  parameter int DEBOUNCE_FRAMES = 10,
  parameter int REPEAT_DELAY = 150,
  parameter int REPEAT_RATE = 40
) (
  input  logic       hwclk,
  input  logic       reset,
  output logic       keypad_r1,
  output logic       keypad_r2,
  output logic       keypad_r3,
  input  logic       keypad_c1,
  input  logic       keypad_c2,
  input  logic       keypad_c3,
  output logic [3:0] button,
  output logic       bstate,
  output logic       key_valid,
  output logic       multi_key
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [7:0] DF = 8'(DEBOUNCE_FRAMES);
  typedef enum logic [1:0] {IDLE, PRESSED, GAP, MULTI} state_t;
  state_t state, state_n;
  logic [CW-1:0] dwell;
  logic [2:0] rows, c_s1, c_s2, closed, sum;
  logic [1:0] row, col, n_row, acc_n, sat;
  logic [3:0] acc_code, code_row, code_cur, cand, prev, pend, pend_n, button_n;
  logic [7:0] stable, stable_n;
  logic last, frame_end, commit, single, kv_n;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] RD = 16'(REPEAT_DELAY);
  localparam logic [15:0] RR = 16'(REPEAT_RATE);
  logic [15:0] rcnt, rcnt_n;
`endif

  assign {keypad_r3, keypad_r2, keypad_r1} = rows;

  // Closed-switch count saturates at 2: only none / one / several matters.
  always_comb begin
    closed = ~c_s2;
    last = dwell == LAST;
    row = !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : 2'd2;
    frame_end = last && row == 2'd2;
    col = closed[0] ? 2'd0 : closed[1] ? 2'd1 : 2'd2;
    n_row = 2'(closed[0]) + 2'(closed[1]) + 2'(closed[2]);
    code_row = 4'(row) * 4'd3 + 4'(col) + 4'd1;
    sum = 3'(acc_n) + 3'(n_row);
    sat = sum > 3'd1 ? 2'd2 : sum[1:0];
    code_cur = n_row != 2'd0 ? code_row : acc_code;
    cand = sat == 2'd0 ? 4'd0 : sat == 2'd1 ? code_cur : 4'hF;
    stable_n = cand != prev ? 8'd1 : stable == DF ? stable : stable + 8'd1;
    commit = frame_end && stable_n == DF && (cand != prev || stable != DF);
    single = cand != 4'd0 && cand != 4'hF;
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      dwell <= '0;
      rows <= 3'b110;
      c_s1 <= 3'b111;
      c_s2 <= 3'b111;
      acc_n <= 2'd0;
      acc_code <= 4'd0;
      prev <= 4'd0;
      stable <= 8'd0;
    end else begin
      c_s1 <= {keypad_c3, keypad_c2, keypad_c1};
      c_s2 <= c_s1;
      dwell <= last ? '0 : dwell + 1'b1;
      if (last) begin
        rows <= {rows[1:0], rows[2]};
        acc_n <= frame_end ? 2'd0 : sat;
        acc_code <= frame_end ? 4'd0 : code_cur;
      end
      if (frame_end) begin
        prev <= cand;
        stable <= stable_n;
      end
    end
  end

  // GAP holds bstate low one cycle so a key change always yields a fresh rising edge.
  always_comb begin
    state_n = state;
    button_n = button;
    pend_n = pend;
    kv_n = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rcnt_n = rcnt;
`endif
    case (state)
      IDLE:
        if (commit && single) begin
          state_n = PRESSED;
          button_n = cand;
          kv_n = 1'b1;
        end else if (commit && cand == 4'hF) state_n = MULTI;
      PRESSED:
        if (commit && cand == 4'd0) state_n = IDLE;
        else if (commit && cand == 4'hF) state_n = MULTI;
        else if (commit && cand != button) begin
          state_n = GAP;
          pend_n = cand;
        end
      GAP: begin
        state_n = PRESSED;
        button_n = pend;
        kv_n = 1'b1;
      end
      MULTI:
        if (commit && cand == 4'd0) state_n = IDLE;
        else if (commit && single) begin
          state_n = PRESSED;
          button_n = cand;
          kv_n = 1'b1;
        end
    endcase
`ifdef KEYPAD_REPEAT_EN
    if (state != PRESSED || state_n != PRESSED) rcnt_n = RD;
    else if (frame_end) begin
      rcnt_n = rcnt == 16'd1 ? RR : rcnt - 16'd1;
      kv_n = rcnt == 16'd1;
    end
`endif
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state <= IDLE;
      button <= 4'd0;
      pend <= 4'd0;
      bstate <= 1'b0;
      key_valid <= 1'b0;
      multi_key <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rcnt <= RD;
`endif
    end else begin
      state <= state_n;
      button <= button_n;
      pend <= pend_n;
      bstate <= state_n == PRESSED;
      key_valid <= kv_n;
      multi_key <= state_n == MULTI;
`ifdef KEYPAD_REPEAT_EN
      rcnt <= rcnt_n;
`endif
    end
  end
endmodule
